// File: rtl/hilo_muldiv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hilo_pkg : op codes, FSM states and constants for the HI/LO mul/div ctrl   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package hilo_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MFHI  = 4'd7,
        MFLO  = 4'd8
    } hilo_op_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIV_RUN = 2'd1,
        S_MUL_RUN = 2'd2,
        S_GAP     = 2'd3
    } hilo_state_t;

    // LO result for a divide by zero; HI takes the dividend
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic op_is_hilo(input hilo_op_t op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU) ||
               (op == MTHI) || (op == MTLO)  || (op == MFHI) || (op == MFLO);
    endfunction

    function automatic logic op_is_signed(input hilo_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hilo_muldiv_ctrl_if : valid_in/valid_out handshake to an iterative unit    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface hilo_muldiv_ctrl_if;

    logic        valid_in;
    logic        sign;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        valid_out;
    logic [31:0] hi;
    logic [31:0] lo;

    // master = controller side, slave = Div/Mult unit side
    modport master (
        output valid_in, sign, src_a, src_b,
        input  valid_out, hi, lo
    );

    modport slave (
        input  valid_in, sign, src_a, src_b,
        output valid_out, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hilo_muldiv_ctrl : HI/LO owner, Div/Mult handshake FSM, watchdog, stall    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  hilo_op_t           op,
    input  logic [31:0]        rs_val,
    input  logic [31:0]        rt_val,
    output logic               stall,
    output logic [31:0]        mf_data,
    output logic               timeout_err,
    hilo_muldiv_ctrl_if.master div_bus,
    hilo_muldiv_ctrl_if.master mul_bus
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    hilo_state_t r_state;
    hilo_state_t w_next;

    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_src_a;
    logic [31:0]     r_src_b;
    logic            r_sign;
    logic [WD_W-1:0] r_wdog;
    logic            r_timeout_err;

    logic w_accept;
    logic w_issue_div;
    logic w_issue_mul;
    logic w_div0;
    logic w_write_hi;
    logic w_write_lo;
    logic w_div_done;
    logic w_mul_done;
    logic w_wd_expire;
    logic w_abort;

    logic        w_div_valid_in;
    logic        w_mul_valid_in;
    logic        w_stall;
    logic [31:0] w_mf_data;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next      = r_state;
        w_issue_div = 1'b0;
        w_issue_mul = 1'b0;
        w_div0      = 1'b0;
        w_write_hi  = 1'b0;
        w_write_lo  = 1'b0;
        w_div_done  = 1'b0;
        w_mul_done  = 1'b0;
        w_abort     = 1'b0;
        w_accept    = op_valid && (r_state == S_IDLE);
        w_wd_expire = (r_wdog == WD_W'(TIMEOUT - 1));

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op)
                        DIV, DIVU: begin
                            // divide by zero is resolved here without touching the unit
                            if (rt_val != 32'd0) begin
                                w_issue_div = 1'b1;
                                w_next      = S_DIV_RUN;
                            end else begin
                                w_div0 = 1'b1;
                            end
                        end
                        MULT, MULTU: begin
                            w_issue_mul = 1'b1;
                            w_next      = S_MUL_RUN;
                        end
                        MTHI:    w_write_hi = 1'b1;
                        MTLO:    w_write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_DIV_RUN: begin
                if (div_bus.valid_out) begin
                    w_div_done = 1'b1;
                    w_next     = S_GAP;
                end else if (w_wd_expire) begin
                    w_abort = 1'b1;
                    w_next  = S_GAP;
                end
            end
            S_MUL_RUN: begin
                if (mul_bus.valid_out) begin
                    w_mul_done = 1'b1;
                    w_next     = S_GAP;
                end else if (w_wd_expire) begin
                    w_abort = 1'b1;
                    w_next  = S_GAP;
                end
            end
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_div_valid_in = (r_state == S_DIV_RUN);
        w_mul_valid_in = (r_state == S_MUL_RUN);
        w_stall        = op_valid && op_is_hilo(op) && (r_state != S_IDLE);
        w_mf_data      = 32'd0;
        if (op_valid && (op == MFHI)) begin
            w_mf_data = r_hi;
        end else if (op_valid && (op == MFLO)) begin
            w_mf_data = r_lo;
        end
    end

    assign stall       = w_stall;
    assign mf_data     = w_mf_data;
    assign timeout_err = r_timeout_err;

    // operands come from the issue-time latch so a stalled next op cannot disturb them
    assign div_bus.valid_in = w_div_valid_in;
    assign div_bus.sign     = r_sign & w_div_valid_in;
    assign div_bus.src_a    = r_src_a;
    assign div_bus.src_b    = r_src_b;

    assign mul_bus.valid_in = w_mul_valid_in;
    assign mul_bus.sign     = r_sign & w_mul_valid_in;
    assign mul_bus.src_a    = r_src_a;
    assign mul_bus.src_b    = r_src_b;

    // ------------------------------------------------ HI/LO, latch, watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi          <= 32'd0;
            r_lo          <= 32'd0;
            r_src_a       <= 32'd0;
            r_src_b       <= 32'd0;
            r_sign        <= 1'b0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_issue_div || w_issue_mul) begin
                r_src_a <= rs_val;
                r_src_b <= rt_val;
                r_sign  <= op_is_signed(op);
            end

            if (w_div0) begin
                r_hi <= rs_val;
                r_lo <= DIV0_LO;
            end
            if (w_write_hi) begin
                r_hi <= rs_val;
            end
            if (w_write_lo) begin
                r_lo <= rs_val;
            end
            // Div reports quotient on hi; MIPS keeps remainder in HI
            if (w_div_done) begin
                r_hi <= div_bus.lo;
                r_lo <= div_bus.hi;
            end
            if (w_mul_done) begin
                r_hi <= mul_bus.hi;
                r_lo <= mul_bus.lo;
            end

            if (w_issue_div || w_issue_mul) begin
                r_wdog <= '0;
            end else if ((r_state == S_DIV_RUN) || (r_state == S_MUL_RUN)) begin
                r_wdog <= r_wdog + WD_W'(1);
            end

            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hilo_muldiv_ctrl : randomized self-checking bench with Div/Mult models  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_hilo_muldiv_ctrl;
    import hilo_pkg::*;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    hilo_op_t    op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic [31:0] mf_data;
    logic        timeout_err;

    hilo_muldiv_ctrl_if div_bus ();
    hilo_muldiv_ctrl_if mul_bus ();

    hilo_muldiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .stall       (stall),
        .mf_data     (mf_data),
        .timeout_err (timeout_err),
        .div_bus     (div_bus),
        .mul_bus     (mul_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // architectural reference state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // ------------------------------------------------------------ unit models
    logic        div_hang = 1'b0, div_spur = 1'b0;
    int          div_cnt = 0, div_lat = 1, div_low_run = 0, div_last_gap = 0;
    int          div_runs = 0, div_unstable = 0;
    logic [31:0] div_a = 0, div_b = 0;

    always @(posedge clk) begin
        if (reset) begin
            div_bus.valid_out <= 1'b0;
            div_bus.hi        <= 32'd0;
            div_bus.lo        <= 32'd0;
            div_cnt = 0;
        end else if (div_spur) begin
            div_bus.valid_out <= 1'b1;
            div_bus.hi        <= 32'hDEAD_BEEF;
            div_bus.lo        <= 32'hBAD0_BAD0;
        end else if (!div_bus.valid_in) begin
            div_bus.valid_out <= 1'b0;
            div_cnt = 0;
            div_low_run++;
        end else begin
            if (div_cnt == 0) begin
                div_last_gap = div_low_run;
                div_low_run  = 0;
                div_runs++;
                div_lat = $urandom_range(1, 6);
                div_a   = div_bus.src_a;
                div_b   = div_bus.src_b;
            end else if (div_bus.src_a !== div_a || div_bus.src_b !== div_b) begin
                div_unstable++;
            end
            div_cnt++;
            if (!div_hang && div_cnt >= div_lat) begin
                div_bus.valid_out <= 1'b1;
                if (div_bus.sign) begin
                    div_bus.hi <= $signed(div_a) / $signed(div_b);
                    div_bus.lo <= $signed(div_a) % $signed(div_b);
                end else begin
                    div_bus.hi <= div_a / div_b;
                    div_bus.lo <= div_a % div_b;
                end
            end
        end
    end

    logic        mul_spur = 1'b0;
    int          mul_cnt = 0, mul_lat = 1, mul_unstable = 0;
    logic [31:0] mul_a = 0, mul_b = 0;
    logic [63:0] mul_p;

    always @(posedge clk) begin
        if (reset) begin
            mul_bus.valid_out <= 1'b0;
            mul_bus.hi        <= 32'd0;
            mul_bus.lo        <= 32'd0;
            mul_cnt = 0;
        end else if (mul_spur) begin
            mul_bus.valid_out <= 1'b1;
            mul_bus.hi        <= 32'h1234_5678;
            mul_bus.lo        <= 32'h9ABC_DEF0;
        end else if (!mul_bus.valid_in) begin
            mul_bus.valid_out <= 1'b0;
            mul_cnt = 0;
        end else begin
            if (mul_cnt == 0) begin
                mul_lat = $urandom_range(1, 6);
                mul_a   = mul_bus.src_a;
                mul_b   = mul_bus.src_b;
            end else if (mul_bus.src_a !== mul_a || mul_bus.src_b !== mul_b) begin
                mul_unstable++;
            end
            mul_cnt++;
            if (mul_cnt >= mul_lat) begin
                if (mul_bus.sign)
                    mul_p = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
                else
                    mul_p = {32'd0, mul_a} * {32'd0, mul_b};
                mul_bus.valid_out <= 1'b1;
                mul_bus.hi        <= mul_p[63:32];
                mul_bus.lo        <= mul_p[31:0];
            end
        end
    end

    // ------------------------------------------------------- reference model
    task automatic apply_model(input hilo_op_t o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (o)
            MULT: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            DIV, DIVU: begin
                if (b == 32'd0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else if (o == DIV) begin
                    m_hi = $signed(a) % $signed(b);
                    m_lo = $signed(a) / $signed(b);
                end else begin
                    m_hi = a % b;
                    m_lo = a / b;
                end
            end
            MTHI:    m_hi = a;
            MTLO:    m_lo = a;
            default: ;
        endcase
    endtask

    // Presents one op (called #1 after posedge); holds it while stalled, returns
    // the stall count and mf_data seen in the accepting cycle.
    task automatic drive_op(input hilo_op_t o, input logic [31:0] a, input logic [31:0] b,
                            output int stalls, output logic [31:0] mf);
        logic done;
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        stalls   = 0;
        mf       = 32'd0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!stall) begin
                mf   = mf_data;
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL stall_bound: op %s still stalled after %0d cycles, required release", o.name(), stalls);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = NONE;
    endtask

    task automatic exec(input hilo_op_t o, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output logic [31:0] mf);
        drive_op(o, a, b, stalls, mf);
        apply_model(o, a, b);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        reset    = 1'b1;
        op_valid = 1'b1;
        op       = MFHI;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, div_bus.valid_in, mul_bus.valid_in, timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: stall/dvi/mvi/terr=%b required 0000",
                     {stall, div_bus.valid_in, mul_bus.valid_in, timeout_err});
        end
        checks++;
        if (mf_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_hi: mf_data=%h required 00000000", mf_data);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        op_valid = 1'b0;
        op       = NONE;
    endtask

    task automatic test_divu();
        int s; logic [31:0] mf; int runs0;
        runs0 = div_runs;
        exec(DIVU, 32'd100, 32'd7, s, mf);
        checks++;
        if (s !== 0) begin errors++; $display("FAIL divu_issue_stall: stalls=%0d required 0", s); end
        exec(MFHI, 0, 0, s, mf);
        checks++;
        if (s == 0) begin errors++; $display("FAIL divu_mfhi_stall: stalls=%0d required >0", s); end
        checks++;
        if (mf !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h required 00000002", mf); end
        exec(MFLO, 0, 0, s, mf);
        checks++;
        if (mf !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h required 0000000e", mf); end
        checks++;
        if (div_runs !== runs0 + 1) begin errors++; $display("FAIL divu_runs: got %0d required %0d", div_runs, runs0 + 1); end
    endtask

    task automatic test_div_signed();
        int s; logic [31:0] mf;
        exec(DIV, 32'hFFFF_FFF9, 32'd2, s, mf);
        exec(MFHI, 0, 0, s, mf);
        checks++;
        if (mf !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h required ffffffff", mf); end
        exec(MFLO, 0, 0, s, mf);
        checks++;
        if (mf !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h required fffffffd", mf); end
    endtask

    task automatic test_div0();
        int s1, s2; logic [31:0] mf; int runs0;
        runs0 = div_runs;
        exec(DIV, 32'd5, 32'd0, s1, mf);
        exec(MFHI, 0, 0, s2, mf);
        checks++;
        if (s1 + s2 !== 0) begin errors++; $display("FAIL div0_stall: stalls=%0d required 0", s1 + s2); end
        checks++;
        if (mf !== 32'd5) begin errors++; $display("FAIL div0_hi: got %h required 00000005", mf); end
        exec(MFLO, 0, 0, s1, mf);
        checks++;
        if (mf !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h required ffffffff", mf); end
        checks++;
        if (div_runs !== runs0) begin errors++; $display("FAIL div0_issued: runs=%0d required %0d", div_runs, runs0); end
    endtask

    task automatic test_multu();
        int s; logic [31:0] mf;
        exec(MULTU, 32'hFFFF_FFFF, 32'd2, s, mf);
        exec(MFHI, 0, 0, s, mf);
        checks++;
        if (s == 0) begin errors++; $display("FAIL multu_mfhi_stall: stalls=%0d required >0", s); end
        checks++;
        if (mf !== 32'd1) begin errors++; $display("FAIL multu_hi: got %h required 00000001", mf); end
        exec(MFLO, 0, 0, s, mf);
        checks++;
        if (mf !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h required fffffffe", mf); end
    endtask

    task automatic test_back_to_back();
        int s; logic [31:0] mf;
        exec(DIVU, 32'd1000, 32'd3, s, mf);
        exec(DIVU, 32'd77, 32'd10, s, mf);
        checks++;
        if (s == 0) begin errors++; $display("FAIL b2b_second_stall: stalls=%0d required >0", s); end
        exec(MFHI, 0, 0, s, mf);
        // low cycles between runs: the GAP cycle plus the IDLE issue cycle
        checks++;
        if (div_last_gap !== 2) begin errors++; $display("FAIL b2b_gap: low cycles=%0d required 2", div_last_gap); end
        checks++;
        if (mf !== 32'd7) begin errors++; $display("FAIL b2b_hi: got %h required 00000007", mf); end
        exec(MFLO, 0, 0, s, mf);
        checks++;
        if (mf !== 32'd7) begin errors++; $display("FAIL b2b_lo: got %h required 00000007", mf); end
    endtask

    task automatic test_spurious();
        int s; logic [31:0] mf;
        div_spur = 1'b1;
        mul_spur = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        div_spur = 1'b0;
        mul_spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exec(MFHI, 0, 0, s, mf);
        checks++;
        if (mf !== m_hi) begin errors++; $display("FAIL spurious_hi: got %h required %h", mf, m_hi); end
        exec(MFLO, 0, 0, s, mf);
        checks++;
        if (mf !== m_lo) begin errors++; $display("FAIL spurious_lo: got %h required %h", mf, m_lo); end
    endtask

    task automatic test_random();
        int s; logic [31:0] mf, expv, a, b; hilo_op_t o;
        for (int i = 0; i < 80; i++) begin
            o = hilo_op_t'($urandom_range(0, 8));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) b = $urandom_range(1, 9);
            if (o == DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            expv = (o == MFHI) ? m_hi : m_lo;
            exec(o, a, b, s, mf);
            if (o == MFHI || o == MFLO) begin
                checks++;
                if (mf !== expv) begin
                    errors++;
                    $display("FAIL rand_%s[%0d]: got %h required %h", o.name(), i, mf, expv);
                end
            end else if (o == NONE) begin
                checks++;
                if (s !== 0) begin errors++; $display("FAIL rand_none_stall[%0d]: stalls=%0d required 0", i, s); end
            end
        end
        exec(MFHI, 0, 0, s, mf);
        checks++;
        if (mf !== m_hi) begin errors++; $display("FAIL rand_final_hi: got %h required %h", mf, m_hi); end
        exec(MFLO, 0, 0, s, mf);
        checks++;
        if (mf !== m_lo) begin errors++; $display("FAIL rand_final_lo: got %h required %h", mf, m_lo); end
        checks++;
        if (div_unstable + mul_unstable !== 0) begin
            errors++;
            $display("FAIL operand_stable: changes=%0d required 0", div_unstable + mul_unstable);
        end
    endtask

    task automatic test_timeout();
        int s, busy, waited; logic [31:0] mf;
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pre: got %b required 0", timeout_err); end
        div_hang = 1'b1;
        drive_op(DIV, 32'd9, 32'd3, s, mf);
        busy   = 0;
        waited = 0;
        while (timeout_err !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
            if (div_bus.valid_in) busy++;
        end
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b required 1", timeout_err); end
        checks++;
        if (busy < TIMEOUT || busy > TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_len: busy cycles=%0d required %0d..%0d", busy, TIMEOUT, TIMEOUT + 1);
        end
        div_hang = 1'b0;
        @(posedge clk);
        #1;
        exec(MFHI, 0, 0, s, mf);
        checks++;
        if (mf !== m_hi) begin errors++; $display("FAIL timeout_hi: got %h required %h", mf, m_hi); end
        exec(MFLO, 0, 0, s, mf);
        checks++;
        if (mf !== m_lo) begin errors++; $display("FAIL timeout_lo: got %h required %h", mf, m_lo); end
        exec(MULT, 32'hFFFF_FFFD, 32'd4, s, mf);
        exec(MFLO, 0, 0, s, mf);
        checks++;
        if (mf !== 32'hFFFF_FFF4) begin errors++; $display("FAIL post_timeout_mult: got %h required fffffff4", mf); end
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b required 1", timeout_err); end
    endtask

    task automatic test_reset_midop();
        int s; logic [31:0] mf;
        exec(MTHI, 32'hCAFE_F00D, 0, s, mf);
        exec(DIVU, 32'd50, 32'd5, s, mf);
        op_valid = 1'b1;
        op       = MFHI;
        #1;
        checks++;
        if ({stall, div_bus.valid_in} !== 2'b11) begin
            errors++;
            $display("FAIL midop_running: stall/dvi=%b required 11", {stall, div_bus.valid_in});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({stall, div_bus.valid_in, timeout_err} !== 3'b000) begin
            errors++;
            $display("FAIL midop_reset_ctrl: stall/dvi/terr=%b required 000", {stall, div_bus.valid_in, timeout_err});
        end
        checks++;
        if (mf_data !== 32'd0) begin errors++; $display("FAIL midop_reset_hi: got %h required 00000000", mf_data); end
        op = MFLO;
        #1;
        checks++;
        if (mf_data !== 32'd0) begin errors++; $display("FAIL midop_reset_lo: got %h required 00000000", mf_data); end
        m_hi = 32'd0;
        m_lo = 32'd0;
        op_valid = 1'b0;
        op       = NONE;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exec(MTLO, 32'h0BAD_CAFE, 0, s, mf);
        exec(MFLO, 0, 0, s, mf);
        checks++;
        if (mf !== 32'h0BAD_CAFE) begin errors++; $display("FAIL post_reset_mtlo: got %h required 0badcafe", mf); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_div_signed();
        test_div0();
        test_multu();
        test_back_to_back();
        test_spurious();
        test_random();
        test_timeout();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
